// File: rtl/rfphoenix_icmiss_pkg.sv
// Shared types and constants for the instruction-cache miss handler.
package rfphoenix_icmiss_pkg;

  // 128-bit beats per 64-byte line
  localparam int unsigned ICACHE_BEATS  = 4;
  localparam int unsigned ICACHE_BEAT_W = 128;
  // 2-bit way number (four ways)
  localparam int unsigned ICACHE_WAY_W  = 2;
  // Byte-offset bits within a line
  localparam int unsigned ICACHE_OFS_W  = 6;
  // Cycles spent after the array write so the hit stage sees the new line
  localparam int unsigned ICACHE_SETTLE = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    FILL   = 3'd2,
    WRITE  = 3'd3,
    SETTLE = 3'd4
  } ic_miss_state_t;

endpackage

// File: rtl/rfphoenix_icmiss_icway_sel.sv
// Victim way selection for a line fill.
// Ports:
//   valid_col - per-way valid bits at the miss index (way 0 first)
//   rr        - round-robin counter, used when every way is valid
//   way_c     - chosen way (combinational)
module rfphoenix_icway_sel
  import rfphoenix_icmiss_pkg::*;
#(
  parameter int unsigned WAYS = 4
) (
  input  logic [0:WAYS-1]         valid_col,
  input  logic [ICACHE_WAY_W-1:0] rr,
  output logic [ICACHE_WAY_W-1:0] way_c
);

  // Lowest-numbered invalid way wins; scan high to low so the last hit is the lowest.
  always_comb begin
    way_c = rr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_col[w]) begin
        way_c = ICACHE_WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/rfphoenix_icmiss.sv
// Instruction-cache miss handler: detects a miss one cycle after the fetch,
// requests the line from memory, gathers the beats, writes the tag/data array
// and maintains the per-way line-valid bits.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   ip, ip_vld, ihit           - fetch address/valid and the registered hit
//   mreq_vld/rdy, mreq_adr     - line request handshake and aligned address
//   mresp_vld/dat/err          - fill beats and bus error
//   wr, wr_way/idx/tag/dat     - tag/data array write
//   valid                      - per-line, per-way valid bits
//   inv_all, inv_line, inv_adr - invalidate controls
//   busy                       - fetch stall
//   err, err_adr               - one-cycle bus-error pulse and failing line
module rfphoenix_icmiss
  import rfphoenix_icmiss_pkg::*;
#(
  parameter int unsigned LINES = 128,
  parameter int unsigned WAYS  = 4,
  parameter int unsigned AWID  = 32,
  parameter int unsigned BEATS = ICACHE_BEATS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [AWID-1:0]                ip,
  input  logic                           ip_vld,
  input  logic                           ihit,
  output logic                           mreq_vld,
  input  logic                           mreq_rdy,
  output logic [AWID-1:0]                mreq_adr,
  input  logic                           mresp_vld,
  input  logic [ICACHE_BEAT_W-1:0]       mresp_dat,
  input  logic                           mresp_err,
  output logic                           wr,
  output logic [ICACHE_WAY_W-1:0]        wr_way,
  output logic [$clog2(LINES)-1:0]       wr_idx,
  output logic [AWID-ICACHE_OFS_W-1:0]   wr_tag,
  output logic [BEATS*ICACHE_BEAT_W-1:0] wr_dat,
  output logic [LINES-1:0][0:WAYS-1]     valid,
  input  logic                           inv_all,
  input  logic                           inv_line,
  input  logic [AWID-1:0]                inv_adr,
  output logic                           busy,
  output logic                           err,
  output logic [AWID-1:0]                err_adr
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SCNT_W = (ICACHE_SETTLE > 1) ? $clog2(ICACHE_SETTLE) : 1;

  ic_miss_state_t state, next_state;

  logic [AWID-1:0]         ip_d;
  logic                    vld_d;
  logic [AWID-1:0]         miss_adr;
  logic [ICACHE_WAY_W-1:0] way;
  logic [ICACHE_WAY_W-1:0] way_sel_c;
  logic [ICACHE_WAY_W-1:0] rr;
  logic [BCNT_W-1:0]       beat;
  logic [SCNT_W-1:0]       settle_cnt;
  logic                    stale;

  logic [IDX_W-1:0] ip_idx, miss_idx, inv_idx;
  logic             miss, beat_acc, last_beat, fill_done, fill_err, settle_done;
  logic             inv_hits_ip, inv_hits_miss;
  logic             mreq_vld_nxt, busy_nxt, wr_nxt, err_nxt;

  assign ip_idx   = ip_d[ICACHE_OFS_W +: IDX_W];
  assign miss_idx = miss_adr[ICACHE_OFS_W +: IDX_W];
  assign inv_idx  = inv_adr[ICACHE_OFS_W +: IDX_W];

  // Offset bits and upper invalidate-address bits carry no information here
  logic unused_bits;
  assign unused_bits = ^{ip_d[ICACHE_OFS_W-1:0], inv_adr[ICACHE_OFS_W-1:0],
                         inv_adr[AWID-1:ICACHE_OFS_W+IDX_W]};

  // Event decode
  assign miss        = (state == IDLE) && vld_d && !ihit;
  assign beat_acc    = (state == FILL) && mresp_vld && !mresp_err;
  assign last_beat   = (beat == BCNT_W'(BEATS - 1));
  assign fill_done   = beat_acc && last_beat;
  assign fill_err    = (state == FILL) && mresp_err;
  assign settle_done = (settle_cnt == SCNT_W'(ICACHE_SETTLE - 1));

  // An invalidate touching the line being fetched makes the fill stale
  assign inv_hits_ip   = inv_all || (inv_line && (inv_idx == ip_idx));
  assign inv_hits_miss = inv_all || (inv_line && (inv_idx == miss_idx));

  rfphoenix_icway_sel #(
    .WAYS (WAYS)
  ) u_way_sel (
    .valid_col (valid[ip_idx]),
    .rr        (rr),
    .way_c     (way_sel_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss) next_state = REQ;
      REQ:     if (mreq_vld && mreq_rdy) next_state = FILL;
      FILL: begin
        if (mresp_err) begin
          next_state = IDLE;
        end else if (fill_done) begin
          next_state = WRITE;
        end
      end
      WRITE:   next_state = SETTLE;
      SETTLE:  if (settle_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    mreq_vld_nxt = 1'b0;
    busy_nxt     = 1'b0;
    wr_nxt       = 1'b0;
    err_nxt      = 1'b0;
    mreq_vld_nxt = (next_state == REQ);
    busy_nxt     = (next_state != IDLE);
    wr_nxt       = fill_done;
    err_nxt      = fill_err;
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreq_vld <= 1'b0;
      busy     <= 1'b0;
      wr       <= 1'b0;
      err      <= 1'b0;
    end else begin
      mreq_vld <= mreq_vld_nxt;
      busy     <= busy_nxt;
      wr       <= wr_nxt;
      err      <= err_nxt;
    end
  end

  // Fetch pipeline register, miss context, beat gathering and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_d       <= '0;
      vld_d      <= 1'b0;
      miss_adr   <= '0;
      way        <= '0;
      rr         <= '0;
      beat       <= '0;
      settle_cnt <= '0;
      stale      <= 1'b0;
      wr_dat     <= '0;
      err_adr    <= '0;
    end else begin
      ip_d  <= ip;
      vld_d <= ip_vld;

      if (miss) begin
        miss_adr <= {ip_d[AWID-1:ICACHE_OFS_W], ICACHE_OFS_W'(0)};
        way      <= way_sel_c;
        beat     <= '0;
        stale    <= inv_hits_ip;
      end else if (((state == REQ) || (state == FILL)) && inv_hits_miss) begin
        stale <= 1'b1;
      end

      if (beat_acc) begin
        for (int b = 0; b < int'(BEATS); b++) begin
          if (beat == BCNT_W'(b)) begin
            wr_dat[b*ICACHE_BEAT_W +: ICACHE_BEAT_W] <= mresp_dat;
          end
        end
        beat <= beat + BCNT_W'(1);
      end

      if (state == WRITE) begin
        rr <= rr + ICACHE_WAY_W'(1);
      end

      if (state == SETTLE) begin
        settle_cnt <= settle_cnt + SCNT_W'(1);
      end else begin
        settle_cnt <= '0;
      end

      if (fill_err) begin
        err_adr <= miss_adr;
      end
    end
  end

  // Valid bits: set alongside the array write, invalidates applied last so they win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (fill_done && !stale) begin
        valid[miss_idx][way] <= 1'b1;
      end
      if (inv_line) begin
        valid[inv_idx] <= '0;
      end
      if (inv_all) begin
        valid <= '0;
      end
    end
  end

  assign mreq_adr = miss_adr;
  assign wr_way   = way;
  assign wr_idx   = miss_idx;
  assign wr_tag   = miss_adr[AWID-1:ICACHE_OFS_W];

endmodule
